// File: rtl/microwave_cook_ctrl.sv
// Microwave cooking controller: mode FSM, seconds countdown, saturating
// time editor, power-level heater duty cycler and finish/beep hold.
// Owns remain_time; all outputs are decoded from registers except lamp.
module microwave_cook_ctrl #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int TIME_W       = 14,
   parameter int MAX_TIME     = 5999,
   parameter int STEP         = 10,
   parameter int POWER_LEVELS = 4,
   parameter int FINISH_HOLD  = 5,
   parameter int PW_W         = $clog2(POWER_LEVELS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btnU,
   input  logic              btnD,
   input  logic              btnL,
   input  logic              btnC,
   input  logic              btnR,
   input  logic              door,
   output logic [2:0]        mode,
   output logic [TIME_W-1:0] remain_time,
   output logic [PW_W-1:0]   power_lvl,
   output logic              heater_en,
   output logic              beep,
   output logic              lamp
);

   localparam int PS_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int HOLD_W = $clog2(FINISH_HOLD + 1);

   localparam logic [PS_W-1:0]   PS_MAX   = PS_W'(CLK_HZ - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(FINISH_HOLD);
   localparam logic [PW_W-1:0]   PW_MAX   = PW_W'(POWER_LEVELS - 1);
   localparam logic [TIME_W-1:0] MAX_T    = TIME_W'(MAX_TIME);
   localparam logic [TIME_W-1:0] STEP_T   = TIME_W'(STEP);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SET    = 3'd1,
      S_RUN    = 3'd2,
      S_STOP   = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   state_t              state_reg,  state_next;
   logic [TIME_W-1:0]   remain_reg, remain_next;
   logic [PW_W-1:0]     power_reg,  power_next;
   logic [PS_W-1:0]     presc_reg,  presc_next;
   logic [PW_W-1:0]     duty_reg,   duty_next;
   logic [HOLD_W-1:0]   hold_reg,   hold_next;
   logic                tick;

   // Add STEP, clamping at MAX_TIME; computed one bit wider so it cannot wrap.
   function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] v);
      logic [TIME_W:0] s;
      s = {1'b0, v} + {1'b0, STEP_T};
      return (s > {1'b0, MAX_T}) ? MAX_T : s[TIME_W-1:0];
   endfunction

   // Remove STEP, clamping at zero.
   function automatic logic [TIME_W-1:0] sat_sub(input logic [TIME_W-1:0] v);
      return (v < STEP_T) ? '0 : (v - STEP_T);
   endfunction

   assign tick = (presc_reg == PS_MAX);

   // State and datapath registers, asynchronously reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         remain_reg <= '0;
         power_reg  <= PW_MAX;
         presc_reg  <= '0;
         duty_reg   <= '0;
         hold_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         remain_reg <= remain_next;
         power_reg  <= power_next;
         presc_reg  <= presc_next;
         duty_reg   <= duty_next;
         hold_reg   <= hold_next;
      end
   end

   // Next-state logic: per-state priority decode of buttons, door and tick.
   always_comb begin
      state_next  = state_reg;
      remain_next = remain_reg;
      power_next  = power_reg;
      presc_next  = presc_reg;
      duty_next   = duty_reg;
      hold_next   = '0;

      // Seconds prescaler only runs while cooking or holding the finish beep.
      if (state_reg == S_RUN || state_reg == S_FINISH)
         presc_next = tick ? '0 : presc_reg + PS_W'(1);

      // Duty phase advances once per second of cooking.
      if (state_reg == S_RUN && tick)
         duty_next = (duty_reg == PW_MAX) ? '0 : duty_reg + PW_W'(1);

      case (state_reg)
         S_IDLE: begin
            if (btnC)
               state_next = S_SET;
         end
         S_SET: begin
            // An unusable btnC (door open or no time) falls through to the rest.
            if (btnC && !door && remain_reg != '0) begin
               state_next = S_RUN;
               presc_next = '0;
               duty_next  = '0;
            end else if (btnL)
               remain_next = '0;
            else if (btnU)
               remain_next = sat_add(remain_reg);
            else if (btnD)
               remain_next = sat_sub(remain_reg);
            else if (btnR)
               power_next = (power_reg == PW_MAX) ? '0 : power_reg + PW_W'(1);
         end
         S_RUN: begin
            if (door)
               state_next = S_STOP;
            else if (btnL)
               state_next = S_SET;
            else if (btnC)
               state_next = S_STOP;
            else if (tick) begin
               // remain is never 0 in RUN, so the decrement cannot underflow.
               if (btnU)
                  remain_next = sat_add(remain_reg - TIME_W'(1));
               else if (remain_reg == TIME_W'(1)) begin
                  state_next  = S_FINISH;
                  remain_next = '0;
                  presc_next  = '0;
               end else
                  remain_next = remain_reg - TIME_W'(1);
            end else if (btnU)
               remain_next = sat_add(remain_reg);
         end
         S_STOP: begin
            // Prescaler and duty are left untouched so the second resumes in phase.
            if (btnC && !door)
               state_next = S_RUN;
            else if (btnL)
               state_next = S_SET;
         end
         S_FINISH: begin
            hold_next = hold_reg;
            if (btnC || btnL) begin
               state_next  = S_SET;
               remain_next = '0;
               hold_next   = '0;
            end else if (tick) begin
               if (hold_reg + HOLD_W'(1) == HOLD_MAX) begin
                  state_next  = S_SET;
                  remain_next = '0;
                  hold_next   = '0;
               end else
                  hold_next = hold_reg + HOLD_W'(1);
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign mode        = state_reg;
   assign remain_time = remain_reg;
   assign power_lvl   = power_reg;
   assign heater_en   = (state_reg == S_RUN) && (duty_reg <= power_reg);
   assign beep        = (state_reg == S_FINISH);
   assign lamp        = door | (state_reg == S_RUN);

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// Directed bench for microwave_cook_ctrl with a cycle-level behavioural
// model compared on every falling edge, plus hand-computed literal checks.
module tb_microwave_cook_ctrl;

   localparam int CLK_HZ = 10;
   localparam int MAX_T  = 60;
   localparam int STEP   = 10;
   localparam int PL     = 4;
   localparam int HOLD   = 5;

   localparam int B_U = 0, B_D = 1, B_L = 2, B_C = 3, B_R = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnC = 1'b0, btnR = 1'b0;
   logic       door = 1'b0;
   logic [2:0] mode;
   logic [13:0] remain_time;
   logic [1:0] power_lvl;
   logic       heater_en, beep, lamp;

   int  tests = 0;
   int  fails = 0;
   bit  chk_en = 1'b0;

   // Model state: mode number, seconds left, power, cycles into current
   // second, seconds cooked since start, seconds spent in FINISH.
   int m_mode = 0, m_remain = 0, m_power = PL - 1;
   int m_sub = 0, m_secs = 0, m_fin = 0;

   microwave_cook_ctrl #(
      .CLK_HZ(CLK_HZ), .TIME_W(14), .MAX_TIME(MAX_T), .STEP(STEP),
      .POWER_LEVELS(PL), .FINISH_HOLD(HOLD)
   ) dut (
      .clk(clk), .reset(reset),
      .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnC(btnC), .btnR(btnR),
      .door(door),
      .mode(mode), .remain_time(remain_time), .power_lvl(power_lvl),
      .heater_en(heater_en), .beep(beep), .lamp(lamp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int add_t(input int v);
      return (v + STEP > MAX_T) ? MAX_T : v + STEP;
   endfunction

   function automatic int sub_t(input int v);
      return (v < STEP) ? 0 : v - STEP;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_remain = 0; m_power = PL - 1;
      m_sub = 0; m_secs = 0; m_fin = 0;
   endtask

   // Advance the model over one rising edge using the inputs now applied.
   task automatic model_step();
      bit counting, tk;
      int nm;
      counting = (m_mode == 2 || m_mode == 4);
      tk = counting && (m_sub == CLK_HZ - 1);
      if (counting) m_sub = (m_sub + 1) % CLK_HZ;
      if (m_mode == 2 && tk) m_secs++;
      nm = m_mode;
      case (m_mode)
         0: if (btnC) nm = 1;
         1: begin
            if (btnC && !door && m_remain > 0) begin
               nm = 2; m_sub = 0; m_secs = 0;
            end else if (btnL) m_remain = 0;
            else if (btnU) m_remain = add_t(m_remain);
            else if (btnD) m_remain = sub_t(m_remain);
            else if (btnR) m_power = (m_power + 1) % PL;
         end
         2: begin
            if (door) nm = 3;
            else if (btnL) nm = 1;
            else if (btnC) nm = 3;
            else if (tk) begin
               if (btnU) m_remain = add_t(m_remain - 1);
               else if (m_remain == 1) begin
                  nm = 4; m_remain = 0; m_sub = 0; m_fin = 0;
               end else m_remain = m_remain - 1;
            end else if (btnU) m_remain = add_t(m_remain);
         end
         3: begin
            if (btnC && !door) nm = 2;
            else if (btnL) nm = 1;
         end
         4: begin
            if (btnC || btnL) begin
               nm = 1; m_remain = 0;
            end else if (tk) begin
               m_fin++;
               if (m_fin == HOLD) begin
                  nm = 1; m_remain = 0;
               end
            end
         end
         default: nm = 0;
      endcase
      if (nm != 4) m_fin = 0;
      m_mode = nm;
   endtask

   // Every falling edge: compare all outputs with the model, then step it.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            int  e_heat, e_beep, e_lamp;
            if (reset) model_reset();
            e_heat = (m_mode == 2 && (m_secs % PL) <= m_power) ? 1 : 0;
            e_beep = (m_mode == 4) ? 1 : 0;
            e_lamp = (door || m_mode == 2) ? 1 : 0;
            tests++;
            if (int'(mode) != m_mode || int'(remain_time) != m_remain ||
                int'(power_lvl) != m_power || int'(heater_en) != e_heat ||
                int'(beep) != e_beep || int'(lamp) != e_lamp) begin
               fails++;
               $display("FAIL cycle_model t=%0t: got mode=%0d remain=%0d pwr=%0d heat=%0d beep=%0d lamp=%0d, expected mode=%0d remain=%0d pwr=%0d heat=%0d beep=%0d lamp=%0d",
                        $time, mode, remain_time, power_lvl, heater_en, beep, lamp,
                        m_mode, m_remain, m_power, e_heat, e_beep, e_lamp);
            end
            if (!reset) model_step();
         end
      end
   end

   // One-cycle button pulse, applied just after a rising edge.
   task automatic press(input int b);
      string nm;
      case (b)
         B_U: begin btnU = 1'b1; nm = "U"; end
         B_D: begin btnD = 1'b1; nm = "D"; end
         B_L: begin btnL = 1'b1; nm = "L"; end
         B_C: begin btnC = 1'b1; nm = "C"; end
         default: begin btnR = 1'b1; nm = "R"; end
      endcase
      @(posedge clk); #1;
      btnU = 1'b0; btnD = 1'b0; btnL = 1'b0; btnC = 1'b0; btnR = 1'b0;
      $display("[TB] t=%0t btn%s door=%0d -> mode=%0d remain=%0d power=%0d heater=%0d",
               $time, nm, door, mode, remain_time, power_lvl, heater_en);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_mode(input int m, input int budget);
      int n = 0;
      while (int'(mode) != m && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_mode", int'(mode), m);
   endtask

   initial begin
      bit [7:0] heat_pat;
      heat_pat = 8'b0011_0011;

      // Asynchronous reset before any clock edge.
      #2 reset = 1'b1; chk_en = 1'b1;
      #1;
      check("rst_mode", int'(mode), 0);
      check("rst_remain", int'(remain_time), 0);
      check("rst_power", int'(power_lvl), 3);
      check("rst_heater", int'(heater_en), 0);
      check("rst_beep", int'(beep), 0);
      check("rst_lamp", int'(lamp), 0);
      door = 1'b1; #1;
      check("rst_lamp_door", int'(lamp), 1);
      door = 1'b0;
      cycles(2);
      reset = 1'b0;
      $display("[TB] t=%0t reset released", $time);

      // Time editing and saturation.
      press(B_C);            check("idle_to_set", int'(mode), 1);
      repeat (3) press(B_U); check("add_30", int'(remain_time), 30);
      repeat (5) press(B_U); check("add_sat_60", int'(remain_time), 60);
      repeat (7) press(B_D); check("sub_floor_0", int'(remain_time), 0);
      press(B_C);            check("start_zero_ignored", int'(mode), 1);

      // 20 s cook: FINISH exactly 200 cycles after the start edge.
      repeat (2) press(B_U);
      press(B_C);
      check("run_start", int'(mode), 2);
      check("run_heater_on", int'(heater_en), 1);
      cycles(199);
      check("run_before_finish", int'(mode), 2);
      check("run_last_second", int'(remain_time), 1);
      cycles(1);
      check("finish_mode", int'(mode), 4);
      check("finish_remain", int'(remain_time), 0);
      check("finish_beep", int'(beep), 1);
      cycles(49);
      check("finish_hold", int'(mode), 4);
      cycles(1);
      check("finish_auto_exit", int'(mode), 1);
      check("finish_exit_beep", int'(beep), 0);

      // Door interrupt at 15 s left, 3 cycles into the second.
      repeat (2) press(B_U);
      press(B_C);
      cycles(53);
      check("run_at_15", int'(remain_time), 15);
      door = 1'b1; #1;
      check("heater_before_edge", int'(heater_en), 1);
      cycles(1);
      check("door_stop", int'(mode), 3);
      check("door_heater_off", int'(heater_en), 0);
      check("door_lamp", int'(lamp), 1);
      press(B_C);
      check("resume_door_open", int'(mode), 3);
      door = 1'b0;
      press(B_C);
      check("resume_run", int'(mode), 2);
      cycles(5);
      check("resume_phase_hold", int'(remain_time), 15);
      cycles(1);
      check("resume_phase_tick", int'(remain_time), 14);
      press(B_L);
      check("run_to_set", int'(mode), 1);
      check("run_to_set_keep", int'(remain_time), 14);

      // Power level 1: heater on two of every four seconds.
      press(B_R); check("power_wrap", int'(power_lvl), 0);
      press(B_R); check("power_1", int'(power_lvl), 1);
      press(B_L);
      press(B_U);
      press(B_C);
      for (int k = 0; k < 8; k++) begin
         cycles((k == 0) ? 5 : 10);
         check($sformatf("duty_sec%0d", k), int'(heater_en), int'(heat_pat[k]));
      end
      press(B_L);
      check("duty_run_remain", int'(remain_time), 3);

      // Same-cycle events.
      press(B_C);
      door = 1'b1; btnL = 1'b1;
      cycles(1);
      door = 1'b0; btnL = 1'b0;
      $display("[TB] t=%0t door+btnL -> mode=%0d", $time, mode);
      check("door_beats_btnL", int'(mode), 3);
      press(B_L);
      check("stop_to_set", int'(mode), 1);
      check("stop_to_set_keep", int'(remain_time), 3);
      press(B_C);
      cycles(29);
      check("tick_btnU_pre", int'(remain_time), 1);
      press(B_U);
      check("tick_btnU_remain", int'(remain_time), 10);
      check("tick_btnU_mode", int'(mode), 2);
      wait_mode(4, 150);
      check("ack_beep_on", int'(beep), 1);
      press(B_C);
      check("ack_mode", int'(mode), 1);
      check("ack_remain", int'(remain_time), 0);
      check("ack_beep_off", int'(beep), 0);

      // Reset between clock edges in the middle of a cook.
      press(B_U);
      press(B_C);
      cycles(3);
      #2 reset = 1'b1;
      #1;
      $display("[TB] t=%0t async reset mid-run", $time);
      check("arst_mode", int'(mode), 0);
      check("arst_remain", int'(remain_time), 0);
      check("arst_heater", int'(heater_en), 0);
      check("arst_power", int'(power_lvl), 3);
      @(posedge clk); #1;
      reset = 1'b0;
      cycles(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/microwave_cook_ctrl.md
# microwave_cook_ctrl

Parametrised microwave cooking controller. It combines the mode FSM with an internal seconds countdown, a saturating time editor, a power-level heater duty cycler and a finish/beep hold with acknowledge. It sits between the debounced button/door inputs and the FND/LED/heater drivers, and owns `remain_time` rather than taking it as an input.

## Interface
Parameters:
- `CLK_HZ`, default 100_000_000: clock cycles per 1 s tick.
- `TIME_W`, default 14: width of `remain_time`, in seconds.
- `MAX_TIME`, default 5999: saturation ceiling for `remain_time` (99:59); must be < 2^TIME_W.
- `STEP`, default 10: seconds added or removed per btnU/btnD.
- `POWER_LEVELS`, default 4: number of power levels (≥2); `PW_W` = $clog2(POWER_LEVELS).
- `FINISH_HOLD`, default 5: ticks spent in FINISH before auto-return.

Ports:
- `clk`, in, 1: system clock; the only clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `btnU`, `btnD`, `btnL`, `btnC`, `btnR`, in, 1 each: single-cycle pulses from upstream debouncers.
- `door`, in, 1: 0 = closed, 1 = open; level input.
- `mode`, out, 3: IDLE=0, SET=1, RUN=2, STOP=3, FINISH=4; registered state.
- `remain_time`, out, TIME_W: seconds remaining; registered.
- `power_lvl`, out, PW_W: 0 = lowest, POWER_LEVELS-1 = full; registered.
- `heater_en`, out, 1: magnetron enable.
- `beep`, out, 1: high throughout FINISH.
- `lamp`, out, 1: cavity lamp = `door` OR (`mode`==RUN); combinational.

## Operation
- Prescaler: 0..CLK_HZ-1; `tick` = (prescaler==CLK_HZ-1).
  - Counts in RUN and FINISH; holds in SET/STOP/IDLE.
  - Cleared on entry to RUN from SET and on entry to FINISH; resumes from its held value on STOP→RUN.
- Duty counter `duty` (0..POWER_LEVELS-1, wraps): advances on `tick` in RUN, held in STOP, cleared on SET→RUN.
  - `heater_en` = (mode==RUN) AND (`duty` ≤ `power_lvl`). Full level = continuously on; level p = p+1 of every POWER_LEVELS seconds.
- Time arithmetic: add = min(remain+STEP, MAX_TIME); sub = (remain<STEP) ? 0 : remain-STEP. No wrap in either direction.
- When several inputs occur in one cycle, only the highest-priority action listed for the current state is taken.
- IDLE: btnC→SET. All other inputs ignored.
- SET: priority btnC > btnL > btnU > btnD > btnR.
  - btnC with !door and remain≠0 → RUN; otherwise btnC is ignored.
  - btnL: remain←0.
  - btnU: add. btnD: sub.
  - btnR: `power_lvl` increments, wrapping to 0 after POWER_LEVELS-1.
- RUN: priority door > btnL > btnC > tick > btnU.
  - door→STOP. btnL→SET, remain retained. btnC→STOP.
  - tick: remain←remain-1; if remain was 1 → FINISH in the same edge, with remain=0.
  - btnU: add, stay in RUN.
  - tick together with btnU: remain←min(remain-1+STEP, MAX_TIME), stay in RUN, no FINISH.
- STOP: btnC with !door → RUN; btnL → SET, remain retained; otherwise stay in STOP.
- FINISH: a hold counter counts ticks.
  - On reaching FINISH_HOLD → SET with remain=0.
  - btnC or btnL → SET immediately (acknowledge), remain=0.
  - Hold counter is cleared whenever the state is not FINISH.
- No path returns to IDLE except reset.

## Timing
- Reset values, applied asynchronously with no clock edge needed:
  - mode=0, remain_time=0, power_lvl=POWER_LEVELS-1.
  - prescaler, duty and hold counters = 0.
  - heater_en=0, beep=0; lamp follows `door`.
- All state and register updates happen on the clk edge that samples the pulse. `mode` reflects the new state one cycle after the pulse.
- `heater_en` and `beep` are decoded from registers: zero additional latency after `mode`/`duty` change, and no glitching from inputs.
- Door opening in RUN: heater_en falls 1 cycle after `door` rises.
- RUN of N seconds started from SET: FINISH is entered exactly N·CLK_HZ cycles after the btnC edge.
- FINISH auto-exit: FINISH_HOLD·CLK_HZ cycles after entry.

## Test plan
Parameters for all tests: CLK_HZ=10, MAX_TIME=60, STEP=10, POWER_LEVELS=4, FINISH_HOLD=5.
- Reset then btnC → mode=1. 3×btnU → remain=30. 5 more btnU → remain=60 (saturated). 7×btnD → remain=0; btnC in this state keeps mode=1.
- remain=20, door=0, btnC → mode=2, heater_en=1. Exactly 200 cycles later: mode=4, remain=0, beep=1. 50 cycles later: mode=1, beep=0.
- RUN at remain=15, door=1 → mode=3, heater_en=0, lamp=1. btnC with door=1 → stays 3. door=0 then btnC → mode=2, countdown continues 15→14 with no lost prescaler phase.
- SET with btnR ×2 → power_lvl 3→0→1. RUN 8 s → heater_en pattern on,on,off,off,on,on,off,off (per second).
- Same-cycle events in RUN: door+btnL → mode=3. remain=1 with tick+btnU → remain=10, mode=2. FINISH + btnC → mode=1 next cycle.
- Assert reset mid-RUN between clock edges → mode=0, remain=0, heater_en=0 immediately.
